hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline's single-cycle load-use hazard detector. A per-register countdown scoreboard tracks pending writes with configurable load and mul/div latencies. It stalls ID-stage consumers until producer results can be forwarded, and blocks back-to-back mul/div issue while the unit is busy. It also generates branch/JR flush and keeps a saturating stall-cycle performance counter; it sits between the ID stage and the ID/EX pipeline register.

---
 rtl/hazard_scoreboard.sv | 183 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Pipeline hazard unit placed between the ID stage and the ID/EX register.
// It keeps one countdown counter per architectural register. The counter holds
// the number of cycles a consumer must still wait before the producer's result
// can be forwarded. ID-stage readers of a pending register are stalled. A
// mul/div busy counter blocks back-to-back mul/div issue. Taken branches and
// jump-register flush the front of the pipe. A saturating counter records the
// total number of stall cycles.
//
// Parameters
//   REG_ADDR_W : register-number width, NREG = 2**REG_ADDR_W entries
//   LOAD_LAT   : stall cycles owed to a consumer of a load result
//   MD_LAT     : stall cycles owed to a consumer of a mul/div result, and
//                the time the mul/div unit stays busy
//   CNT_W      : width of the stall_cycles performance counter
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   id_valid      : ID stage holds a valid instruction
//   rs/rt_num_ID  : source register numbers
//   rs/rt_used_ID : the instruction actually reads rs / rt
//   reg_write_ID  : the instruction writes rd_num_ID
//   rd_num_ID     : destination register number
//   op_class_ID   : 00 ALU, 01 LOAD, 10 MULDIV, 11 treated as ALU
//   branch_taken  : branch resolved taken in ID
//   jr            : jump-register in ID
//   stat_clear    : synchronous clear of stall_cycles
//   stall         : hold PC and IF/ID, insert a bubble into ID/EX
//   flush         : squash IF/ID and ID/EX
//   issue         : the ID instruction moves into EX this cycle
//   stall_reason  : {structural mul/div, RAW data}
//   stall_cycles  : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int MD_LAT     = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs_num_ID,
    input  logic [REG_ADDR_W-1:0] rt_num_ID,
    input  logic                  rs_used_ID,
    input  logic                  rt_used_ID,
    input  logic                  reg_write_ID,
    input  logic [REG_ADDR_W-1:0] rd_num_ID,
    input  logic [1:0]            op_class_ID,
    input  logic                  branch_taken,
    input  logic                  jr,
    input  logic                  stat_clear,
    output logic                  stall,
    output logic                  flush,
    output logic                  issue,
    output logic [1:0]            stall_reason,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int NREG    = 1 << REG_ADDR_W;
    localparam int MAX_LAT = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
    // With both latencies at zero the counters are never loaded with anything
    // but 0; keep them one bit wide so the vectors stay legal.
    localparam int SB_W    = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    localparam logic [1:0]      OP_LOAD   = 2'b01;
    localparam logic [1:0]      OP_MULDIV = 2'b10;
    localparam logic [SB_W-1:0] LOAD_CNT  = SB_W'(LOAD_LAT);
    localparam logic [SB_W-1:0] MD_CNT    = SB_W'(MD_LAT);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [SB_W-1:0]  cnt_q [NREG];
    logic [SB_W-1:0]  cnt_d [NREG];
    logic [SB_W-1:0]  md_busy_q;
    logic [SB_W-1:0]  md_busy_d;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] stall_cycles_d;

    // -------------------------------------------------------------------------
    // Hazard detection (purely combinational from inputs and current state)
    // -------------------------------------------------------------------------
    logic rs_pending;
    logic rt_pending;
    logic raw_hit;
    logic md_hit;
    logic is_muldiv;
    logic flush_w;
    logic stall_w;
    logic issue_w;

    assign is_muldiv  = (op_class_ID == OP_MULDIV);
    assign rs_pending = rs_used_ID && (cnt_q[rs_num_ID] != '0);
    assign rt_pending = rt_used_ID && (cnt_q[rt_num_ID] != '0);
    assign raw_hit    = id_valid && (rs_pending || rt_pending);
    assign md_hit     = id_valid && is_muldiv && (md_busy_q != '0);

    // A redirect squashes the ID instruction, so any hazard it has is moot.
    assign flush_w = branch_taken || jr;
    assign stall_w = !flush_w && (raw_hit || md_hit);
    assign issue_w = id_valid && !stall_w && !flush_w;

    assign flush        = flush_w;
    assign stall        = stall_w;
    assign issue        = issue_w;
    assign stall_reason = flush_w ? 2'b00 : {md_hit, raw_hit};
    assign stall_cycles = stall_cycles_q;

    // -------------------------------------------------------------------------
    // Scoreboard next state
    // -------------------------------------------------------------------------
    logic            wr_track;
    logic [SB_W-1:0] wr_value;

    // r0 is hard-wired zero, so writes to it never create a hazard.
    assign wr_track = issue_w && reg_write_ID && (rd_num_ID != '0);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        wr_value = '0;
        case (op_class_ID)
            OP_LOAD:   wr_value = LOAD_CNT;
            OP_MULDIV: wr_value = MD_CNT;
            default:   wr_value = '0;
        endcase
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
            // A new producer overwrites the entry, even with a smaller value,
            // since the youngest writer is the one consumers will forward from.
            if (wr_track && (rd_num_ID == REG_ADDR_W'(r))) begin
                cnt_d[r] = wr_value;
            end
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        md_busy_d = (md_busy_q != '0) ? md_busy_q - 1'b1 : '0;
        if (issue_w && is_muldiv) begin
            md_busy_d = MD_CNT;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stat_clear) begin
            stall_cycles_d = '0;
        end else if (stall_w && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the scoreboard array is reset on purpose; a stale pending
            // count left behind after reset would stall the first consumer.
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            md_busy_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            md_busy_q      <= md_busy_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard (defaults, CNT_W = 3 so the stall
// counter saturates quickly). A driver applies one vector per cycle and
// pushes the hand-computed response for that cycle into a queue. A monitor
// pops one entry on every falling edge and compares it against the outputs.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int CNT_W = 3;
    localparam logic [1:0] ALU = 2'b00;
    localparam logic [1:0] LD  = 2'b01;
    localparam logic [1:0] MD  = 2'b10;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [4:0]       rs_num_ID;
    logic [4:0]       rt_num_ID;
    logic             rs_used_ID;
    logic             rt_used_ID;
    logic             reg_write_ID;
    logic [4:0]       rd_num_ID;
    logic [1:0]       op_class_ID;
    logic             branch_taken;
    logic             jr;
    logic             stat_clear;
    logic             stall;
    logic             flush;
    logic             issue;
    logic [1:0]       stall_reason;
    logic [CNT_W-1:0] stall_cycles;

    hazard_scoreboard #(
        .REG_ADDR_W (5),
        .LOAD_LAT   (1),
        .MD_LAT     (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .rs_num_ID    (rs_num_ID),
        .rt_num_ID    (rt_num_ID),
        .rs_used_ID   (rs_used_ID),
        .rt_used_ID   (rt_used_ID),
        .reg_write_ID (reg_write_ID),
        .rd_num_ID    (rd_num_ID),
        .op_class_ID  (op_class_ID),
        .branch_taken (branch_taken),
        .jr           (jr),
        .stat_clear   (stat_clear),
        .stall        (stall),
        .flush        (flush),
        .issue        (issue),
        .stall_reason (stall_reason),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       stall;
        logic       flush;
        logic       issue;
        logic [1:0] reason;
        int         sc;       // expected stall_cycles, -1 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One cycle of stimulus plus the response expected during that cycle.
    task automatic step(input string name, input logic v,
                        input int rs, input int rt, input logic ru, input logic tu,
                        input logic rw, input int rd, input logic [1:0] op,
                        input logic br, input logic j, input logic clr,
                        input logic es, input logic ef, input logic ei,
                        input logic [1:0] er, input int esc);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid     = v;
        rs_num_ID    = 5'(rs);
        rt_num_ID    = 5'(rt);
        rs_used_ID   = ru;
        rt_used_ID   = tu;
        reg_write_ID = rw;
        rd_num_ID    = 5'(rd);
        op_class_ID  = op;
        branch_taken = br;
        jr           = j;
        stat_clear   = clr;
        e.name   = name;
        e.stall  = es;
        e.flush  = ef;
        e.issue  = ei;
        e.reason = er;
        e.sc     = esc;
        exp_q.push_back(e);
    endtask

    // Monitor: compares one queued expectation per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".stall"},  32'(stall),        32'(e.stall));
                check({e.name, ".flush"},  32'(flush),        32'(e.flush));
                check({e.name, ".issue"},  32'(issue),        32'(e.issue));
                check({e.name, ".reason"}, 32'(stall_reason), 32'(e.reason));
                if (e.sc >= 0) begin
                    check({e.name, ".stall_cycles"}, 32'(stall_cycles), 32'(e.sc));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst          = 1'b1;
        id_valid     = 1'b0;
        rs_num_ID    = '0;
        rt_num_ID    = '0;
        rs_used_ID   = 1'b0;
        rt_used_ID   = 1'b0;
        reg_write_ID = 1'b0;
        rd_num_ID    = '0;
        op_class_ID  = ALU;
        branch_taken = 1'b0;
        jr           = 1'b0;
        stat_clear   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        //    name              v  rs rt ru tu rw rd  op   br j clr  st fl is rsn sc
        step("reset_idle",      0, 0, 0, 0, 0, 0, 0,  ALU, 0, 0, 0,  0, 0, 0, 0,  0);
        // Load-use: exactly one stall cycle.
        step("ld_r5_issue",     1, 1, 2, 1, 0, 1, 5,  LD,  0, 0, 0,  0, 0, 1, 0,  0);
        step("ld_use_stall",    1, 5, 2, 1, 0, 1, 6,  ALU, 0, 0, 0,  1, 0, 0, 1,  0);
        step("ld_use_issue",    1, 5, 2, 1, 0, 1, 6,  ALU, 0, 0, 0,  0, 0, 1, 0,  1);
        // Mul/div RAW with an independent ALU op in between.
        step("md_r7_issue",     1, 1, 2, 1, 1, 1, 7,  MD,  0, 0, 0,  0, 0, 1, 0,  1);
        step("alu_r3_free",     1, 3, 0, 1, 0, 1, 8,  ALU, 0, 0, 0,  0, 0, 1, 0,  1);
        step("md_use_stall1",   1, 0, 7, 0, 1, 1, 9,  ALU, 0, 0, 0,  1, 0, 0, 1,  1);
        step("md_use_stall2",   1, 0, 7, 0, 1, 1, 9,  ALU, 0, 0, 0,  1, 0, 0, 1,  2);
        step("md_use_stall3",   1, 0, 7, 0, 1, 1, 9,  ALU, 0, 0, 0,  1, 0, 0, 1,  3);
        step("md_use_issue",    1, 0, 7, 0, 1, 1, 9,  ALU, 0, 0, 0,  0, 0, 1, 0,  4);
        // Structural: back-to-back mul/div, four stalls, counter saturates at 7.
        step("md_r10_issue",    1, 1, 2, 1, 1, 1, 10, MD,  0, 0, 0,  0, 0, 1, 0,  4);
        step("md_struct1",      1, 3, 4, 1, 1, 1, 11, MD,  0, 0, 0,  1, 0, 0, 2,  4);
        step("md_struct2",      1, 3, 4, 1, 1, 1, 11, MD,  0, 0, 0,  1, 0, 0, 2,  5);
        step("md_struct3",      1, 3, 4, 1, 1, 1, 11, MD,  0, 0, 0,  1, 0, 0, 2,  6);
        step("md_struct4",      1, 3, 4, 1, 1, 1, 11, MD,  0, 0, 0,  1, 0, 0, 2,  7);
        step("md_r11_issue",    1, 3, 4, 1, 1, 1, 11, MD,  0, 0, 0,  0, 0, 1, 0,  7);
        // Structural plus RAW on r11; stat_clear wins over the increment.
        step("md_both1",        1, 11, 4, 1, 1, 1, 12, MD, 0, 0, 0,  1, 0, 0, 3,  7);
        step("md_both2_clr",    1, 11, 4, 1, 1, 1, 12, MD, 0, 0, 1,  1, 0, 0, 3,  7);
        step("md_both3",        1, 11, 4, 1, 1, 1, 12, MD, 0, 0, 0,  1, 0, 0, 3,  0);
        step("md_both4",        1, 11, 4, 1, 1, 1, 12, MD, 0, 0, 0,  1, 0, 0, 3,  1);
        step("md_r12_issue",    1, 11, 4, 1, 1, 1, 12, MD, 0, 0, 0,  0, 0, 1, 0,  2);
        // Register 0 is never tracked.
        step("ld_r0",           1, 1, 2, 1, 0, 1, 0,  LD,  0, 0, 0,  0, 0, 1, 0,  2);
        step("r0_use",          1, 0, 0, 1, 1, 1, 18, ALU, 0, 0, 0,  0, 0, 1, 0,  2);
        // Branch flush during a RAW hazard; the scoreboard keeps counting.
        step("ld_r13",          1, 1, 2, 1, 0, 1, 13, LD,  0, 0, 0,  0, 0, 1, 0,  2);
        step("br_flush",        1, 13, 0, 1, 0, 1, 19, ALU, 1, 0, 0, 0, 1, 0, 0,  2);
        step("post_br_issue",   1, 13, 0, 1, 0, 1, 19, ALU, 0, 0, 0, 0, 0, 1, 0,  2);
        // Jump-register flush behaves the same.
        step("ld_r14",          1, 1, 2, 1, 0, 1, 14, LD,  0, 0, 0,  0, 0, 1, 0,  2);
        step("jr_flush",        1, 14, 0, 1, 0, 1, 20, ALU, 0, 1, 0, 0, 1, 0, 0,  2);
        step("post_jr_issue",   1, 14, 0, 1, 0, 1, 20, ALU, 0, 0, 0, 0, 0, 1, 0,  2);
        // WAW: a younger load overwrites the larger mul/div count on r15.
        step("md_r15",          1, 1, 2, 1, 1, 1, 15, MD,  0, 0, 0,  0, 0, 1, 0,  2);
        step("ld_r15_waw",      1, 1, 2, 1, 0, 1, 15, LD,  0, 0, 0,  0, 0, 1, 0,  2);
        step("waw_stall",       1, 15, 0, 1, 0, 0, 0, ALU, 0, 0, 0,  1, 0, 0, 1,  2);
        step("waw_issue",       1, 15, 0, 1, 0, 0, 0, ALU, 0, 0, 0,  0, 0, 1, 0,  3);
        step("idle",            0, 0, 0, 0, 0, 0, 0,  ALU, 0, 0, 0,  0, 0, 0, 0,  3);
        // Reset in the middle of a mul/div RAW stall.
        step("md_r16",          1, 1, 2, 1, 1, 1, 16, MD,  0, 0, 0,  0, 0, 1, 0,  3);
        step("rst_pre_stall",   1, 16, 0, 1, 0, 0, 0, ALU, 0, 0, 0,  1, 0, 0, 1,  3);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_async.stall",  32'(stall),        32'd0);
        check("rst_async.reason", 32'(stall_reason), 32'd0);
        check("rst_async.issue",  32'(issue),        32'd1);
        #1 rst = 1'b0;
        step("rst_post_issue",  1, 16, 0, 1, 0, 0, 0, ALU, 0, 0, 0,  0, 0, 1, 0,  0);
        step("final_idle",      0, 0, 0, 0, 0, 0, 0,  ALU, 0, 0, 0,  0, 0, 0, 0,  0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
